demux_dff: RTL
==============

# demux_dff

Registered 1-to-2 demultiplexer for PE datapaths. It accepts one valid/ready input stream and steers each beat into one of two single-entry output registers, each with its own valid/ready handshake. Each output keeps a per-output beat counter for power-analysis activity accounting. It is the splitting counterpart of the registered 2:1 select-and-register stage used in the PE accumulation path.

## Interface
- `data_width`, default 24: width of the data path.
- `cnt_width`, default 16: width of each per-output beat counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `clear`  in  1  synchronous flush of both output registers; counters are not affected.
- `in_data`  in  data_width  input beat.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  input beat accepted this cycle when `in_valid & in_ready`.
- `sel`  in  1  destination of the current input beat: 0 = out0, 1 = out1.
- `out0_data`  out  data_width  output register 0.
- `out0_valid`  out  1  out0 holds a beat.
- `out0_ready`  in  1  consumer 0 takes the beat.
- `out1_data`, `out1_valid`, `out1_ready`: same as out0, for destination 1.
- `out0_cnt`  out  cnt_width  beats delivered on out0 (`out0_valid & out0_ready`).
- `out1_cnt`  out  cnt_width  beats delivered on out1.

## Operation
- Destination `d`:
  - without the macro: `d = sel`;
  - with the macro: `d = ptr`, the internal ping-pong pointer.
- Slot `k` can accept when it is empty or draining this cycle: `!outk_valid | outk_ready`.
- `in_ready = !clear & (slot d can accept)`. The path from `in_ready` to `outk_ready` and `sel` is combinational; this is intentional and gives full throughput.
- On accept (`in_valid & in_ready`):
  - `outd_data <= in_data`;
  - `outd_valid <= 1`.
- On drain (`outk_valid & outk_ready`) with no new accept into slot k: `outk_valid <= 0`. Data is held, not zeroed.
- Drain and accept into the same slot in the same cycle: the slot is reloaded and stays valid (back-to-back, no bubble).
- The other slot is independent. It may drain in the same cycle another slot is loaded.
- `outk_data` is stable while `outk_valid & !outk_ready`. No overwrite of an undrained beat is possible.
- `clear = 1`:
  - next edge: `out0_valid = out1_valid = 0`;
  - `in_ready = 0` during clear, so an input beat presented with clear is not accepted;
  - a beat drained while clear is high still counts;
  - `ptr <= 0` (macro build).
- Counters: increment by 1 on each drain of their slot. They wrap modulo 2^cnt_width; there is no saturation flag.
- `sel` is ignored when `in_valid = 0`.

## Timing
- Latency: a beat accepted at edge N appears on `outd_valid`/`outd_data` after edge N, in cycle N+1.
- Throughput: 1 beat/cycle when the selected consumer holds ready high.
- Reset (`rst_n = 0`, asynchronous, any time including mid-transfer):
  - `out0_valid = out1_valid = 0`;
  - `out0_data = out1_data = 0`;
  - `out0_cnt = out1_cnt = 0`;
  - `ptr = 0`;
  - `in_ready` evaluates from the reset state, so it is 1 unless `clear` is high.
- Reset release: the first accept can occur on the first rising edge after `rst_n` goes high.
- Counter update is visible in the cycle after the drain edge.

## Configuration
- `DEMUX_DFF_PINGPONG_EN` defined:
  - `sel` is ignored;
  - 1-bit register `ptr` selects the destination;
  - `ptr` toggles on every accepted beat and resets/clears to 0;
  - if slot `ptr` cannot accept, input stalls even when the other slot is empty. Strict alternation is preserved.
- `DEMUX_DFF_PINGPONG_EN` not defined: no `ptr` register; steering is purely by `sel`.

## Test plan
- Reset mid-stream: load out0 with `0xABCDEF`, assert `rst_n = 0` asynchronously -> outputs go immediately to valid=0, data=0, cnt=0.
- Steering with both outputs ready, `in_valid` held: input `0x000001`..`0x000004` with sel 0,1,1,0 -> out0 sees 1 then 4, out1 sees 2 then 3, each one cycle after accept; `out0_cnt = out1_cnt = 2`.
- Backpressure: `out1_ready = 0`, send two beats with sel=1 -> first is held in out1 with stable data, second sees `in_ready = 0`. A concurrent sel=0 beat, after the sel=1 beat is withdrawn, is still accepted into out0. Raise `out1_ready` -> second beat loads with no bubble.
- Clear collision: out0 valid, `clear = 1` with `in_valid = 1` -> `in_ready = 0`; both valids are 0 next cycle; counters are unchanged unless a drain coincided.
- Counter wrap with `cnt_width = 4`: 17 drains on out0 -> `out0_cnt = 1`.
- Macro build: sel held at 0, 4 beats, both outputs ready -> beats alternate out0, out1, out0, out1. With `out1_ready = 0` after beat 2, beat 4 stalls even though out0 is free.

Source files
------------

// File: rtl/demux_dff_if.sv
// Handshake bundle for demux_dff: one valid/ready input stream, two registered
// valid/ready outputs with per-output beat counters, plus the synchronous flush.
interface demux_dff_if #(
    parameter int unsigned data_width = 24,
    parameter int unsigned cnt_width  = 16
);
    logic                  clear;
    logic [data_width-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  sel;
    logic [data_width-1:0] out0_data;
    logic                  out0_valid;
    logic                  out0_ready;
    logic [data_width-1:0] out1_data;
    logic                  out1_valid;
    logic                  out1_ready;
    logic [cnt_width-1:0]  out0_cnt;
    logic [cnt_width-1:0]  out1_cnt;

    modport master (
        output clear, in_data, in_valid, sel, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid, out0_cnt, out1_cnt
    );

    modport slave (
        input  clear, in_data, in_valid, sel, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid, out0_cnt, out1_cnt
    );
endinterface

// File: rtl/demux_dff.sv
// Registered 1-to-2 demultiplexer with single-entry output slots and per-output
// beat counters. Define DEMUX_DFF_PINGPONG_EN to steer by an alternating pointer.
module demux_dff #(
    parameter int unsigned data_width = 24,
    parameter int unsigned cnt_width  = 16
) (
    input logic       clk,
    input logic       rst_n,
    demux_dff_if.slave bus
);
    logic [data_width-1:0] out0_data_q, out1_data_q;
    logic                  out0_valid_q, out1_valid_q;
    logic                  out0_valid_d, out1_valid_d;
    logic [cnt_width-1:0]  out0_cnt_q, out1_cnt_q;

    logic dest;
    logic can0, can1;
    logic accept, load0, load1;
    logic drain0, drain1;

`ifdef DEMUX_DFF_PINGPONG_EN
    logic ptr_q;
    assign dest = ptr_q;
`else
    assign dest = bus.sel;
`endif

    // A slot may take a new beat when empty or when its current beat leaves this cycle.
    assign can0   = !out0_valid_q || bus.out0_ready;
    assign can1   = !out1_valid_q || bus.out1_ready;
    assign accept = bus.in_valid && bus.in_ready;
    assign load0  = accept && !dest;
    assign load1  = accept && dest;
    assign drain0 = out0_valid_q && bus.out0_ready;
    assign drain1 = out1_valid_q && bus.out1_ready;

    assign bus.in_ready = !bus.clear && (dest ? can1 : can0);

    always_comb begin
        out0_valid_d = out0_valid_q;
        out1_valid_d = out1_valid_q;
        if (drain0) out0_valid_d = 1'b0;
        if (drain1) out1_valid_d = 1'b0;
        if (load0)  out0_valid_d = 1'b1;
        if (load1)  out1_valid_d = 1'b1;
        if (bus.clear) begin
            out0_valid_d = 1'b0;
            out1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_data_q  <= '0;
            out1_data_q  <= '0;
            out0_valid_q <= 1'b0;
            out1_valid_q <= 1'b0;
            out0_cnt_q   <= '0;
            out1_cnt_q   <= '0;
        end else begin
            if (load0) out0_data_q <= bus.in_data;
            if (load1) out1_data_q <= bus.in_data;
            out0_valid_q <= out0_valid_d;
            out1_valid_q <= out1_valid_d;
            // Drains count even during clear; counters wrap freely.
            if (drain0) out0_cnt_q <= out0_cnt_q + cnt_width'(1);
            if (drain1) out1_cnt_q <= out1_cnt_q + cnt_width'(1);
        end
    end

`ifdef DEMUX_DFF_PINGPONG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (bus.clear) begin
            ptr_q <= 1'b0;
        end else if (accept) begin
            ptr_q <= !ptr_q;
        end
    end
`endif

    assign bus.out0_data  = out0_data_q;
    assign bus.out1_data  = out1_data_q;
    assign bus.out0_valid = out0_valid_q;
    assign bus.out1_valid = out1_valid_q;
    assign bus.out0_cnt   = out0_cnt_q;
    assign bus.out1_cnt   = out1_cnt_q;
endmodule
